// File: rtl/get_fsm_if.sv
// Memory read bus and response channel of the GET sub-FSM.
// The master modport is the FSM side; the slave modport is the memory/consumer side.
interface get_fsm_if #(
  parameter int NUM_ENTRIES = 16,
  parameter int VALUE_WIDTH = 32
);
  logic                   select_out;
  logic                   read_out;
  logic [NUM_ENTRIES-1:0] idx_out;
  logic [VALUE_WIDTH-1:0] rd_data;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [VALUE_WIDTH-1:0] resp_data;

  modport master (
    output select_out,
    output read_out,
    output idx_out,
    input  rd_data,
    output resp_valid,
    input  resp_ready,
    output resp_data
  );

  modport slave (
    input  select_out,
    input  read_out,
    input  idx_out,
    output rd_data,
    input  resp_valid,
    output resp_ready,
    input  resp_data
  );
endinterface

// File: rtl/get_fsm.sv
// GET sub-FSM of the cache controller: reads a hit entry over READ_LAT cycles
// and returns it on a valid/ready channel, then reports done/error.
package ctrl_types_pkg;
  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;
endpackage

module get_fsm #(
  parameter int NUM_ENTRIES  = 16,
  parameter int VALUE_WIDTH  = 32,
  parameter int READ_LAT     = 2,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       enter,
  input  logic                       hit,
  input  logic [NUM_ENTRIES-1:0]     used,
  input  logic [NUM_ENTRIES-1:0]     idx_in,
  get_fsm_if.master                  bus,
  output logic                       rdy_out,
  output logic                       op_succ,
  output ctrl_types_pkg::sub_cmd_t   cmd
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int TO_W  = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    GET_ST_START,
    GET_ST_READ,
    GET_ST_RESP,
    GET_ST_DONE,
    GET_ST_ERR
  } state_t;

  state_t                 state_q;
  logic [LAT_W-1:0]       lat_cnt_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic [NUM_ENTRIES-1:0] idx_q;
  logic [VALUE_WIDTH-1:0] resp_data_q;
  logic                   hit_good;

  // A hit is only serviceable when it names exactly one occupied entry.
  assign hit_good = hit && $onehot(idx_in) && ((idx_in & used) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GET_ST_START;
      lat_cnt_q   <= '0;
      to_cnt_q    <= '0;
      idx_q       <= '0;
      resp_data_q <= '0;
    end else if (enter) begin
      state_q   <= GET_ST_START;
      lat_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else if (en) begin
      case (state_q)
        GET_ST_START: begin
          if (hit_good) begin
            idx_q     <= idx_in;
            lat_cnt_q <= '0;
            state_q   <= GET_ST_READ;
          end
        end
        GET_ST_READ: begin
          if (lat_cnt_q == LAT_LAST) begin
            resp_data_q <= bus.rd_data;
            to_cnt_q    <= '0;
            state_q     <= GET_ST_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        GET_ST_RESP: begin
          // A handshake on the final wait cycle still counts as a transfer.
          if (bus.resp_ready) begin
            state_q <= GET_ST_DONE;
          end else if (to_cnt_q == TO_LAST) begin
            state_q <= GET_ST_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_data = resp_data_q;

  // Outputs are a decode of the state; START also reflects the live hit result.
  always_comb begin
    bus.select_out = 1'b0;
    bus.read_out   = 1'b0;
    bus.idx_out    = '0;
    bus.resp_valid = 1'b0;
    rdy_out        = 1'b0;
    op_succ        = 1'b0;
    cmd            = '0;
    if (!rst) begin
      case (state_q)
        GET_ST_START: begin
          if (!hit) begin
            cmd.done = 1'b1;
            rdy_out  = 1'b1;
          end else if (!hit_good) begin
            cmd.done  = 1'b1;
            cmd.error = 1'b1;
            rdy_out   = 1'b1;
          end
        end
        GET_ST_READ: begin
          bus.select_out = 1'b1;
          bus.read_out   = 1'b1;
          bus.idx_out    = idx_q;
        end
        GET_ST_RESP: begin
          bus.resp_valid = 1'b1;
        end
        GET_ST_DONE: begin
          cmd.done = 1'b1;
          op_succ  = 1'b1;
          rdy_out  = 1'b1;
        end
        GET_ST_ERR: begin
          cmd.done  = 1'b1;
          cmd.error = 1'b1;
          rdy_out   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_get_fsm.sv
// Self-checking bench for get_fsm: START decode table, directed multi-cycle
// sequences and randomized traffic against a transaction-level model.
module tb_get_fsm;
  import ctrl_types_pkg::*;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int RL = 2;
  localparam int RT = 8;

  logic clk = 1'b0;
  logic rst, en, enter, hit;
  logic [N-1:0] used, idxIn;
  logic rdyOut, opSucc;
  sub_cmd_t cmd;

  get_fsm_if #(.NUM_ENTRIES(N), .VALUE_WIDTH(W)) bus();

  get_fsm #(
    .NUM_ENTRIES(N), .VALUE_WIDTH(W), .READ_LAT(RL), .RESP_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .enter(enter), .hit(hit),
    .used(used), .idx_in(idxIn), .bus(bus),
    .rdy_out(rdyOut), .op_succ(opSucc), .cmd(cmd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: an operation in flight, en-cycles since it was accepted, unready
  // response cycles so far, and its final outcome (0 none, 1 done, 2 error).
  bit           mBusy;
  int           mElapsed;
  int           mWait;
  int           mOutcome;
  logic [W-1:0] mData;
  logic [N-1:0] mIdx;

  typedef struct {
    logic         hit;
    logic [N-1:0] idx;
    logic [N-1:0] used;
    logic         expDone;
    logic         expErr;
    logic         expRdy;
  } vec_t;

  function automatic bit serviceable();
    return hit && ($countones(idxIn) == 1) && ((idxIn & used) != '0);
  endfunction

  // 0 idle, 1 reading, 2 responding, 3 delivered, 4 failed
  function automatic int phase();
    if (!mBusy) return 0;
    if (mOutcome == 1) return 3;
    if (mOutcome == 2) return 4;
    if (mElapsed < RL) return 1;
    return 2;
  endfunction

  // {select, read, idx_out, resp_valid, rdy, op_succ, done, error}
  function automatic logic [22:0] expectedOut();
    logic sel, rd, rv, rdy, succ, dn, er;
    logic [N-1:0] ix;
    {sel, rd, rv, rdy, succ, dn, er} = '0;
    ix = '0;
    if (!rst) begin
      case (phase())
        0: if (!serviceable()) begin dn = 1; rdy = 1; er = hit; end
        1: begin sel = 1; rd = 1; ix = mIdx; end
        2: rv = 1;
        3: begin dn = 1; succ = 1; rdy = 1; end
        default: begin dn = 1; er = 1; rdy = 1; end
      endcase
    end
    return {sel, rd, ix, rv, rdy, succ, dn, er};
  endfunction

  function automatic logic [22:0] actualOut();
    return {bus.select_out, bus.read_out, bus.idx_out, bus.resp_valid,
            rdyOut, opSucc, cmd.done, cmd.error};
  endfunction

  task automatic modelUpdate();
    int ph;
    ph = phase();
    if (rst) begin
      mBusy = 0; mElapsed = 0; mWait = 0; mOutcome = 0; mData = '0; mIdx = '0;
    end else if (enter) begin
      mBusy = 0; mOutcome = 0;
    end else if (en) begin
      if (ph == 0 && serviceable()) begin
        mBusy = 1; mElapsed = 0; mWait = 0; mOutcome = 0; mIdx = idxIn;
      end else if (ph == 1) begin
        mElapsed++;
        if (mElapsed == RL) mData = bus.rd_data;
      end else if (ph == 2) begin
        if (bus.resp_ready) mOutcome = 1;
        else begin
          mWait++;
          if (mWait == RT) mOutcome = 2;
        end
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    @(negedge clk);
    checkVal(name, 64'(actualOut()), 64'(expectedOut()));
    if (!rst && phase() == 2) checkVal({name, "_data"}, 64'(bus.resp_data), 64'(mData));
  endtask

  task automatic advance();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic ent, input logic h,
                               input logic [N-1:0] ix, input logic [N-1:0] u,
                               input logic [W-1:0] rd, input logic rdy);
    rst = r; en = e; enter = ent; hit = h; idxIn = ix; used = u;
    bus.rd_data = rd; bus.resp_ready = rdy;
  endtask

  task automatic resetDut();
    applyStimulus(1, 1, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_out");
      advance();
    end
    checkVal("reset_data", 64'(bus.resp_data), 64'h0);
    rst = 0;
  endtask

  // Drive a standard hit on entry 4 and leave the operation to the caller.
  task automatic startHit(input logic rdy, input logic [W-1:0] rd);
    applyStimulus(0, 1, 0, 1, 16'h0010, 16'h00FF, rd, rdy);
  endtask

  task automatic runTimeout(input int readyAt, input string name);
    int valids;
    valids = 0;
    resetDut();
    startHit(0, 32'h1234_5678);
    for (int i = 0; i < 20; i++) begin
      checkOutput(name);
      if (bus.resp_valid) valids++;
      advance();
      if (readyAt != 0 && valids == readyAt - 1) bus.resp_ready = 1;
    end
    checkVal({name, "_valid_cycles"}, 64'(valids), 64'(RT));
    checkOutput(name);
    checkVal({name, "_done"}, 64'(cmd.done), 64'h1);
    checkVal({name, "_error"}, 64'(cmd.error), 64'(readyAt == 0));
    checkVal({name, "_succ"}, 64'(opSucc), 64'(readyAt != 0));
    advance();
  endtask

  initial begin
    vec_t vecs[9];
    int reads, valids, firstValid;
    logic [W-1:0] held;

    mBusy = 0; mElapsed = 0; mWait = 0; mOutcome = 0; mData = '0; mIdx = '0;
    applyStimulus(1, 1, 0, 0, '0, '0, '0, 0);
    @(posedge clk);
    #1;

    resetDut();

    // START decode with en=0 so the state never moves.
    vecs[0] = '{0, 16'h0010, 16'h00FF, 1, 0, 1};
    vecs[1] = '{0, 16'h0011, 16'h0000, 1, 0, 1};
    vecs[2] = '{1, 16'h0011, 16'h00FF, 1, 1, 1};
    vecs[3] = '{1, 16'h0000, 16'hFFFF, 1, 1, 1};
    vecs[4] = '{1, 16'h0100, 16'h00FF, 1, 1, 1};
    vecs[5] = '{1, 16'h0010, 16'h00FF, 0, 0, 0};
    vecs[6] = '{1, 16'h8000, 16'h8000, 0, 0, 0};
    vecs[7] = '{1, 16'h0001, 16'h0001, 0, 0, 0};
    vecs[8] = '{1, 16'hC000, 16'hFFFF, 1, 1, 1};
    foreach (vecs[k]) begin
      applyStimulus(0, 0, 0, vecs[k].hit, vecs[k].idx, vecs[k].used, 32'h0, 0);
      checkOutput("vec_out");
      checkVal($sformatf("vec%0d_done", k), 64'(cmd.done), 64'(vecs[k].expDone));
      checkVal($sformatf("vec%0d_error", k), 64'(cmd.error), 64'(vecs[k].expErr));
      checkVal($sformatf("vec%0d_rdy", k), 64'(rdyOut), 64'(vecs[k].expRdy));
      checkVal($sformatf("vec%0d_read", k), 64'(bus.read_out), 64'h0);
      advance();
    end

    // Plain hit read with the consumer always ready.
    resetDut();
    startHit(1, 32'hDEAD_BEEF);
    reads = 0; valids = 0; firstValid = -1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("hit_read");
      if (bus.read_out) begin
        reads++;
        checkVal("hit_idx_out", 64'(bus.idx_out), 64'h0010);
      end
      if (bus.resp_valid) begin
        valids++;
        if (firstValid < 0) firstValid = i;
        checkVal("hit_resp_data", 64'(bus.resp_data), 64'hDEAD_BEEF);
      end
      advance();
    end
    checkVal("hit_read_cycles", 64'(reads), 64'(RL));
    checkVal("hit_valid_cycles", 64'(valids), 64'h1);
    checkVal("hit_latency", 64'(firstValid), 64'(RL + 1));
    checkOutput("hit_final");
    checkVal("hit_done", 64'(cmd.done), 64'h1);
    checkVal("hit_succ", 64'(opSucc), 64'h1);
    advance();

    runTimeout(0, "timeout");
    runTimeout(RT, "late_ready");

    // en held low for three cycles in the middle of the read.
    resetDut();
    startHit(1, 32'hA5A5_0F0F);
    reads = 0; firstValid = -1;
    for (int i = 0; i < 12; i++) begin
      en = !(i >= 2 && i <= 4);
      checkOutput("en_gate");
      if (bus.read_out) reads++;
      if (bus.resp_valid && firstValid < 0) firstValid = i;
      advance();
    end
    checkVal("en_gate_read_cycles", 64'(reads), 64'(RL + 3));
    checkVal("en_gate_latency", 64'(firstValid), 64'(RL + 1 + 3));

    // enter while waiting in RESP aborts back to START but keeps the data.
    resetDut();
    startHit(0, 32'hCAFE_F00D);
    firstValid = -1;
    for (int i = 0; i < 10 && firstValid < 0; i++) begin
      checkOutput("abort_pre");
      if (bus.resp_valid) firstValid = i;
      advance();
    end
    checkVal("abort_reached_resp", 64'(firstValid), 64'(RL + 1));
    held = mData;
    enter = 1;
    checkOutput("abort_enter");
    advance();
    enter = 0; hit = 0;
    checkOutput("abort_after");
    checkVal("abort_valid", 64'(bus.resp_valid), 64'h0);
    checkVal("abort_done", 64'(cmd.done), 64'h1);
    checkVal("abort_data_kept", 64'(bus.resp_data), 64'hCAFE_F00D);
    checkVal("abort_model_data", 64'(held), 64'hCAFE_F00D);
    advance();

    // Randomized traffic against the model.
    resetDut();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] ix;
      if ($urandom_range(0, 9) < 7) ix = N'(1) << $urandom_range(0, N - 1);
      else ix = N'($urandom);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6,
                    ix, ($urandom_range(0, 1) == 1) ? N'($urandom) : 16'hFFFF,
                    $urandom, $urandom_range(0, 9) < 3);
      checkOutput("rand");
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
